// File: rtl/hs_pkg.sv
// Shared types and helpers for the four-phase req/ack transmit handshake.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_REL,
    FAULT
  } hs_state_t;

  localparam int HS_SYNC_MIN = 2;
  localparam int HS_SYNC_MAX = 4;

  // Bits needed to hold values 0..timeout_cycles; never less than 1.
  function automatic int hs_cnt_width(input int timeout_cycles);
    int w;
    w = 1;
    while ((1 << w) <= timeout_cycles) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Flop-chain synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; stage 0 is the metastable one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/hs_tx.sv
// Transmit side of a four-phase req/ack handshake into an unrelated clock domain.
// req_out and data_out come straight from flops so the receiver never sees glitches.
module hs_tx
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  send,
  output logic                  ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = hs_cnt_width(TIMEOUT_CYCLES);
  // Fault fires on the edge that ends the TIMEOUT_CYCLES-th cycle spent waiting.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  if (SYNC_STAGES < HS_SYNC_MIN || SYNC_STAGES > HS_SYNC_MAX) begin : g_bad_sync
    $error("hs_tx: SYNC_STAGES must be within 2..4");
  end

  hs_state_t             r_state;
  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic w_ack_sync;
  logic w_ready;
  logic w_timeout;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack_in),
    .o_q (w_ack_sync)
  );

  // A stale-high ack after reset keeps us from starting a new cycle.
  assign w_ready   = (r_state == IDLE) && !w_ack_sync;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Handshake FSM with registered req/data/done/error and the per-phase timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (send && w_ready) begin
            r_data  <= data_in;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_ack_sync) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT_REL;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!w_ack_sync) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FAULT: begin
          // Latched until reset.
          r_req <= 1'b0;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready    = w_ready;
  assign req_out  = r_req;
  assign data_out = r_data;
  assign done     = r_done;
  assign error    = r_err;

endmodule

// File: tb/tb_hs_tx.sv
// Directed bench for hs_tx: nominal transfer, back-to-back, stale ack, timeout, reset abort.
module tb_hs_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       send;
  logic       ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen;

  hs_tx #(
    .DATA_WIDTH     (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .send     (send),
    .ready    (ready),
    .req_out  (req_out),
    .data_out (data_out),
    .ack_in   (ack_in),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    send    = 1'b0;
    ack_in  = 1'b0;
    data_in = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(3);

    // 1: reset state
    check_eq("rst_ready", 32'(ready), 32'h1);
    check_eq("rst_req",   32'(req_out), 32'h0);
    check_eq("rst_data",  32'(data_out), 32'h00);
    check_eq("rst_done",  32'(done), 32'h0);
    check_eq("rst_error", 32'(error), 32'h0);

    // 2: nominal transfer of 0xA5, accepted at E0
    send    = 1'b1;
    data_in = 8'hA5;
    tick(1);                                   // E0
    send    = 1'b0;
    data_in = 8'h00;
    check_eq("s2_req_rise", 32'(req_out), 32'h1);
    check_eq("s2_data",     32'(data_out), 32'hA5);
    check_eq("s2_busy",     32'(ready), 32'h0);
    tick(2);                                   // E2: receiver raises ack
    ack_in = 1'b1;
    tick(2);                                   // E4: ack_sync just went high
    check_eq("s2_req_held", 32'(req_out), 32'h1);
    tick(1);                                   // E5: third edge after sample at E3
    check_eq("s2_req_fall", 32'(req_out), 32'h0);
    check_eq("s2_data_rel", 32'(data_out), 32'hA5);
    tick(2);                                   // E7: receiver drops ack
    ack_in = 1'b0;
    tick(2);                                   // E9
    check_eq("s2_no_early_done", 32'(done), 32'h0);
    tick(1);                                   // E10
    check_eq("s2_done",       32'(done), 32'h1);
    check_eq("s2_ready_back", 32'(ready), 32'h1);
    check_eq("s2_data_final", 32'(data_out), 32'hA5);

    // 3: back-to-back send during the done cycle
    send    = 1'b1;
    data_in = 8'h3C;
    tick(1);                                   // E11
    check_eq("s3_req_rise", 32'(req_out), 32'h1);
    check_eq("s3_data",     32'(data_out), 32'h3C);
    check_eq("s3_done_one", 32'(done), 32'h0);
    data_in = 8'hFF;                           // send while busy must be ignored
    tick(1);                                   // E12
    send    = 1'b0;
    check_eq("s3_data_kept", 32'(data_out), 32'h3C);
    ack_in = 1'b1;
    tick(3);                                   // E15
    check_eq("s3_req_fall", 32'(req_out), 32'h0);
    ack_in = 1'b0;
    tick(3);                                   // E18
    check_eq("s3_done", 32'(done), 32'h1);
    check_eq("s3_data_final", 32'(data_out), 32'h3C);

    // 4: stale-high ack across reset release
    ack_in = 1'b1;
    rst    = 1'b1;
    tick(2);
    check_eq("s4_data_cleared", 32'(data_out), 32'h00);
    rst = 1'b0;
    tick(3);
    check_eq("s4_ready_blocked", 32'(ready), 32'h0);
    send    = 1'b1;
    data_in = 8'h77;
    tick(1);
    send    = 1'b0;
    check_eq("s4_send_ignored_req",  32'(req_out), 32'h0);
    check_eq("s4_send_ignored_data", 32'(data_out), 32'h00);
    ack_in = 1'b0;
    tick(1);
    check_eq("s4_ready_still_low", 32'(ready), 32'h0);
    tick(1);
    check_eq("s4_ready_after_2", 32'(ready), 32'h1);

    // 5: timeout with no acknowledge
    send    = 1'b1;
    data_in = 8'h5A;
    tick(1);                                   // enter WAIT_ACK
    send = 1'b0;
    tick(15);
    check_eq("s5_req_at_15", 32'(req_out), 32'h1);
    check_eq("s5_err_at_15", 32'(error), 32'h0);
    tick(1);
    check_eq("s5_req_at_16", 32'(req_out), 32'h0);
    check_eq("s5_err_at_16", 32'(error), 32'h1);
    check_eq("s5_ready_fault", 32'(ready), 32'h0);
    send    = 1'b1;
    data_in = 8'h11;
    tick(1);
    send = 1'b0;
    tick(4);
    check_eq("s5_still_fault", 32'(ready), 32'h0);
    check_eq("s5_err_sticky",  32'(error), 32'h1);
    check_eq("s5_no_done",     32'(done), 32'h0);
    check_eq("s5_data_held",   32'(data_out), 32'h5A);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("s5_err_cleared", 32'(error), 32'h0);
    check_eq("s5_ready_reset", 32'(ready), 32'h1);

    // 6: reset while in WAIT_REL
    send    = 1'b1;
    data_in = 8'hC3;
    tick(1);                                   // B
    send   = 1'b0;
    ack_in = 1'b1;
    tick(3);                                   // B+3: req has dropped
    check_eq("s6_in_wait_rel_req", 32'(req_out), 32'h0);
    check_eq("s6_in_wait_rel_rdy", 32'(ready), 32'h0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    ack_in = 1'b0;
    check_eq("s6_req",  32'(req_out), 32'h0);
    check_eq("s6_data", 32'(data_out), 32'h00);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_seen++;
      tick(1);
    end
    check_eq("s6_no_done", 32'(done_seen), 32'h0);
    check_eq("s6_ready",   32'(ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
